// File: rtl/pwm_spi_loader_if.sv
// SPI pins in from the controller plus the 12-bit write port out to the PWM generator.
// master = loader side, slave = controller/generator side.
interface pwm_spi_loader_if #(
   parameter int DATA_W = 12
);
   logic              spi_sck;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic [DATA_W-1:0] pwm_in;
   logic              pwm_sel;
   logic              pwm_wr_en;

   modport master (
      input  spi_sck, spi_cs_n, spi_mosi,
      output pwm_in, pwm_sel, pwm_wr_en
   );

   modport slave (
      output spi_sck, spi_cs_n, spi_mosi,
      input  pwm_in, pwm_sel, pwm_wr_en
   );
endinterface

// File: rtl/pwm_spi_loader.sv
// SPI-slave front-end that decodes 16-bit frames into PWM period/duty writes.
// Strobe one cycle after cs_rise is seen; no backpressure, the generator must accept every write.
module pwm_spi_loader #(
   parameter int FRAME_BITS  = 16,
   parameter int DATA_W      = 12,
   parameter int DUTY_MAX    = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   pwm_spi_loader_if.master bus,
   input  logic             err_clr,
   output logic             busy,
   output logic             frame_err,
   output logic             clamp_flag
);
   localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [DATA_W-1:0] DUTY_LIM = DATA_W'(DUTY_MAX);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] flush;
   logic                   sck_q;
   logic                   cs_q;
   logic                   cs_armed;
   logic                   sck_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   cs_fall;
   logic                   cs_rise;
   logic [FRAME_BITS-1:0]  shift;
   logic [FRAME_BITS-1:0]  shift_nx;
   logic [CNT_W-1:0]       bit_cnt;
   logic [CNT_W-1:0]       cnt_nx;
   logic [DATA_W-1:0]      data_nx;
   logic                   sel_nx;
   logic                   clamp_nx;

   // cs_armed requires a genuinely high cs_n after reset, so a frame already in flight is ignored.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         flush     <= '0;
         sck_q     <= 1'b0;
         cs_q      <= 1'b1;
         cs_armed  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
         sck_q     <= sck_s;
         cs_q      <= cs_s;
         if (flush[SYNC_STAGES-1] && cs_s) begin
            cs_armed <= 1'b1;
         end
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_q;
   assign cs_fall  = ~cs_s & cs_q & cs_armed;
   assign cs_rise  = cs_s & ~cs_q;

   // Next shift/count include a coincident sck edge so the cs_rise check sees the final bit.
   always_comb begin
      shift_nx = shift;
      cnt_nx   = bit_cnt;
      if (sck_rise) begin
         shift_nx = {shift[FRAME_BITS-2:0], mosi_s};
         if (bit_cnt != CNT_SAT) begin
            cnt_nx = bit_cnt + CNT_W'(1);
         end
      end
      sel_nx   = shift_nx[FRAME_BITS-1];
      clamp_nx = !sel_nx && (shift_nx[DATA_W-1:0] > DUTY_LIM);
      data_nx  = clamp_nx ? DUTY_LIM : shift_nx[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state         <= IDLE;
         shift         <= '0;
         bit_cnt       <= '0;
         bus.pwm_in    <= '0;
         bus.pwm_sel   <= 1'b0;
         bus.pwm_wr_en <= 1'b0;
         busy          <= 1'b0;
         frame_err     <= 1'b0;
         clamp_flag    <= 1'b0;
      end else begin
         bus.pwm_wr_en <= 1'b0;
         if (err_clr) begin
            frame_err  <= 1'b0;
            clamp_flag <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  shift   <= '0;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               shift   <= shift_nx;
               bit_cnt <= cnt_nx;
               if (cs_rise) begin
                  if (cnt_nx == CNT_FULL) begin
                     // Outputs load on entry so the strobe lines up with the COMMIT cycle.
                     state         <= COMMIT;
                     bus.pwm_wr_en <= 1'b1;
                     bus.pwm_sel   <= sel_nx;
                     bus.pwm_in    <= data_nx;
                     if (clamp_nx) begin
                        clamp_flag <= 1'b1;
                     end
                  end else begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     frame_err <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               if (cs_fall) begin
                  state   <= SHIFT;
                  shift   <= '0;
                  bit_cnt <= '0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_spi_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares on each strobe.
module tb_pwm_spi_loader;
   localparam int HALF = 3;

   typedef struct {
      logic        sel;
      logic [11:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   logic err_clr;
   logic busy;
   logic frame_err;
   logic clamp_flag;

   pwm_spi_loader_if #(.DATA_W(12)) bus();

   pwm_spi_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .err_clr    (err_clr),
      .busy       (busy),
      .frame_err  (frame_err),
      .clamp_flag (clamp_flag)
   );

   always #5 clk = ~clk;

   wr_t         exp_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic        m_sel;
   logic [11:0] m_data;
   logic        m_ferr;
   logic        m_clamp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: a frame writes only when exactly 16 bits arrived; duty values above 100 saturate.
   task automatic model_frame(input logic [31:0] v, input int n);
      wr_t w;
      if (n == 16) begin
         w.sel  = v[15];
         w.data = v[11:0];
         if (!w.sel && w.data > 12'd100) begin
            w.data  = 12'd100;
            m_clamp = 1'b1;
         end
         exp_q.push_back(w);
         m_sel  = w.sel;
         m_data = w.data;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input logic exp_busy);
      for (int i = n - 1; i >= 0; i--) begin
         bus.spi_mosi = v[i];
         wait_clk(HALF);
         bus.spi_sck = 1'b1;
         wait_clk(HALF);
         bus.spi_sck = 1'b0;
         if (i == n - 2) chk("busy_mid_frame", busy, exp_busy);
      end
   endtask

   task automatic send_frame(input logic [31:0] v, input int n, input int gap);
      model_frame(v, n);
      bus.spi_cs_n = 1'b0;
      wait_clk(HALF);
      send_bits(v, n, 1'b1);
      wait_clk(HALF);
      bus.spi_cs_n = 1'b1;
      wait_clk(gap);
   endtask

   task automatic check_state(input string tag);
      wait_clk(4);
      chk({tag, "_pwm_in"}, bus.pwm_in, m_data);
      chk({tag, "_pwm_sel"}, bus.pwm_sel, m_sel);
      chk({tag, "_frame_err"}, frame_err, m_ferr);
      chk({tag, "_clamp_flag"}, clamp_flag, m_clamp);
      chk({tag, "_busy_idle"}, busy, 1'b0);
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      m_ferr  = 1'b0;
      m_clamp = 1'b0;
   endtask

   task automatic model_reset();
      m_sel   = 1'b0;
      m_data  = '0;
      m_ferr  = 1'b0;
      m_clamp = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus.pwm_wr_en === 1'b1) begin
            chk("strobe_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_sel", bus.pwm_sel, e.sel);
               chk("wr_data", bus.pwm_in, e.data);
            end
         end
      end
   end

   initial begin
      int          n;
      logic [31:0] v;
      rst_n        = 1'b1;
      err_clr      = 1'b0;
      bus.spi_sck  = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_mosi = 1'b0;
      model_reset();
      wait_clk(4);
      rst_n = 1'b0;
      wait_clk(1);
      chk("rst_pwm_in", bus.pwm_in, 0);
      chk("rst_pwm_sel", bus.pwm_sel, 0);
      chk("rst_wr_en", bus.pwm_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_clamp", clamp_flag, 0);
      wait_clk(6);

      send_frame(32'h83E8, 16, 6);
      check_state("period");
      send_frame(32'h0032, 16, 6);
      check_state("duty50");
      send_frame(32'h0096, 16, 6);
      check_state("duty150");
      pulse_err_clr();
      check_state("clamp_clr");

      send_frame(32'h0155, 10, 6);
      check_state("short10");
      send_frame(32'h1F0F0, 17, 6);
      check_state("long17");
      pulse_err_clr();
      check_state("ferr_clr");

      // Reset lands mid-frame and is released with cs_n still low.
      bus.spi_cs_n = 1'b0;
      wait_clk(HALF);
      send_bits(32'h0F, 8, 1'b1);
      rst_n = 1'b1;
      wait_clk(3);
      model_reset();
      rst_n = 1'b0;
      send_bits(32'hFF, 8, 1'b0);
      wait_clk(HALF);
      bus.spi_cs_n = 1'b1;
      wait_clk(6);
      check_state("mid_reset");
      send_frame(32'h8100, 16, 6);
      check_state("post_reset");

      send_frame(32'h8064, 16, 4);
      send_frame(32'h000A, 16, 6);
      check_state("back_to_back");

      for (int k = 0; k < 25; k++) begin
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
         v = $urandom;
         send_frame(v, n, 6);
         if ($urandom_range(0, 4) == 0) pulse_err_clr();
         check_state("random");
      end

      wait_clk(10);
      chk("pending_strobes", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
